button_debounce: RTL

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/button_debounce.sv
// Per-channel button debouncer: 2-flop synchronizer, debounce FSM, press/release strobes.
// Optional per-channel long-press level, enabled by defining LONG_PRESS_EN.
module button_debounce #(
  parameter int NUM_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES   = 270000,
  parameter int LONG_PRESS_CYCLES = 27000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] button_n,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse
`ifdef LONG_PRESS_EN
  ,
  output logic [NUM_BUTTONS-1:0] long_press
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RELEASED        = 2'd0,
    ST_PRESS_PENDING   = 2'd1,
    ST_PRESSED         = 2'd2,
    ST_RELEASE_PENDING = 2'd3
  } state_e;

  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q, sync;
  state_e                 state_q [NUM_BUTTONS];
  state_e                 state_d [NUM_BUTTONS];
  logic [CNT_W-1:0]       cnt_q   [NUM_BUTTONS];
  logic [CNT_W-1:0]       cnt_d   [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] pressed_q, pressed_d;
  logic [NUM_BUTTONS-1:0] press_pulse_q, press_pulse_d;
  logic [NUM_BUTTONS-1:0] release_pulse_q, release_pulse_d;

  // Pins are active-low; sync is the synchronized pressed level.
  assign sync = ~sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q         <= '1;
      sync2_q         <= '1;
      pressed_q       <= '0;
      press_pulse_q   <= '0;
      release_pulse_q <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i] <= ST_RELEASED;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q         <= button_n;
      sync2_q         <= sync1_q;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    pressed_d       = pressed_q;
    press_pulse_d   = '0;
    release_pulse_d = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      case (state_q[i])
        ST_RELEASED, ST_PRESS_PENDING: begin
          if (!sync[i]) begin
            state_d[i] = ST_RELEASED;
          end else if (cnt_q[i] == CNT_TERM) begin
            state_d[i]       = ST_PRESSED;
            pressed_d[i]     = 1'b1;
            press_pulse_d[i] = 1'b1;
          end else begin
            state_d[i] = ST_PRESS_PENDING;
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        ST_PRESSED, ST_RELEASE_PENDING: begin
          if (sync[i]) begin
            state_d[i] = ST_PRESSED;
          end else if (cnt_q[i] == CNT_TERM) begin
            state_d[i]         = ST_RELEASED;
            pressed_d[i]       = 1'b0;
            release_pulse_d[i] = 1'b1;
          end else begin
            state_d[i] = ST_RELEASE_PENDING;
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i]   = ST_RELEASED;
          pressed_d[i] = 1'b0;
        end
      endcase
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;

`ifdef LONG_PRESS_EN
  localparam int LP_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [LP_W-1:0] LP_TERM = LP_W'(LONG_PRESS_CYCLES);
  localparam logic [LP_W-1:0] LP_ONE  = LP_W'(1);

  logic [LP_W-1:0]        lp_cnt_q [NUM_BUTTONS];
  logic [LP_W-1:0]        lp_cnt_d [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] long_press_q, long_press_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      long_press_q <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        lp_cnt_q[i] <= '0;
      end
    end else begin
      long_press_q <= long_press_d;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        lp_cnt_q[i] <= lp_cnt_d[i];
      end
    end
  end

  // Count cycles spent pressed (saturating); level drops on the same edge as pressed.
  always_comb begin
    long_press_d = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      lp_cnt_d[i] = '0;
      if (pressed_q[i] && pressed_d[i]) begin
        if (lp_cnt_q[i] == LP_TERM) begin
          lp_cnt_d[i] = lp_cnt_q[i];
        end else begin
          lp_cnt_d[i] = lp_cnt_q[i] + LP_ONE;
        end
      end else begin
        lp_cnt_d[i] = '0;
      end
      long_press_d[i] = pressed_d[i] && (lp_cnt_d[i] == LP_TERM);
    end
  end

  assign long_press = long_press_q;
`endif

endmodule
